// File: rtl/pipelined_core_fwd.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) with EX/MEM and MEM/WB forwarding,
// a one-cycle load-use interlock, a program-load port and retire/stall counters.
module pipelined_core_fwd #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic [$clog2(NREGS)-1:0]      dbg_reg_addr,
  output logic [XLEN-1:0]               dbg_reg_data,
  output logic                          retire_valid,
  output logic [31:0]                   retire_count,
  output logic [31:0]                   stall_count
);
  localparam int RW = $clog2(NREGS);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam logic [IW:0] PC_END = (IW+1)'(IMEM_DEPTH);

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLL} alu_op_e;

  logic [31:0]     r_imem [IMEM_DEPTH];
  logic [XLEN-1:0] r_dmem [DMEM_DEPTH];
  logic [XLEN-1:0] r_regs [NREGS];
  logic [IW:0]     r_pc;
  logic [31:0]     r_ifid_instr;

  logic            r_idex_valid, r_idex_wr, r_idex_lw, r_idex_sw, r_idex_use_imm;
  alu_op_e         r_idex_op;
  logic [RW-1:0]   r_idex_rd, r_idex_rs1, r_idex_rs2;
  logic [XLEN-1:0] r_idex_a, r_idex_b, r_idex_imm;

  logic            r_exmem_valid, r_exmem_wr, r_exmem_lw, r_exmem_sw;
  logic [RW-1:0]   r_exmem_rd;
  logic [XLEN-1:0] r_exmem_res, r_exmem_store;

  logic            r_wb_valid, r_wb_wr;
  logic [RW-1:0]   r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic            r_retire_valid;
  logic [31:0]     r_retire_count, r_stall_count;

  logic [31:0]     w_fetch;
  logic [6:0]      w_opcode, w_f7;
  logic [2:0]      w_f3;
  logic            w_is_r, w_is_addi, w_is_slli, w_is_lw, w_is_sw;
  logic            w_id_valid, w_id_wr, w_id_use_rs2, w_id_use_imm, w_stall;
  alu_op_e         w_id_op;
  logic [RW-1:0]   w_id_rd, w_id_rs1, w_id_rs2;
  logic [XLEN-1:0] w_id_imm, w_id_a, w_id_b;
  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_res, w_dmem_rdata;
  logic [DW-1:0]   w_dmem_idx;

  // Past the end of IMEM the PC parks and fetch feeds all-zero bubbles.
  assign w_fetch = (r_pc < PC_END) ? r_imem[r_pc[IW-1:0]] : 32'd0;

  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_addr] <= imem_wdata;
  end

  always_comb begin
    w_opcode     = r_ifid_instr[6:0];
    w_f3         = r_ifid_instr[14:12];
    w_f7         = r_ifid_instr[31:25];
    w_is_r       = (w_opcode == 7'b0110011) && (w_f3 == 3'b000);
    w_is_addi    = (w_opcode == 7'b0010011) && (w_f3 == 3'b000);
    w_is_slli    = (w_opcode == 7'b0010011) && (w_f3 == 3'b001);
    w_is_lw      = (w_opcode == 7'b0000011) && (w_f3 == 3'b010);
    w_is_sw      = (w_opcode == 7'b0100011) && (w_f3 == 3'b010);
    w_id_valid   = w_is_r | w_is_addi | w_is_slli | w_is_lw | w_is_sw;
    w_id_rd      = RW'(r_ifid_instr[11:7]);
    w_id_rs1     = RW'(r_ifid_instr[19:15]);
    w_id_rs2     = RW'(r_ifid_instr[24:20]);
    w_id_wr      = (w_is_r | w_is_addi | w_is_slli | w_is_lw) && (w_id_rd != '0);
    w_id_use_rs2 = w_is_r | w_is_sw;
    w_id_use_imm = w_is_addi | w_is_lw | w_is_sw;
    w_id_op      = ALU_ADD;
    if (w_is_slli) w_id_op = ALU_SLL;
    else if (w_is_r && (w_f7 == 7'b0100000)) w_id_op = ALU_SUB;
    w_id_imm = w_is_sw ? {{(XLEN-12){r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]}
                       : {{(XLEN-12){r_ifid_instr[31]}}, r_ifid_instr[31:20]};
    // Write-first register file: the WB write is bypassed into the ID read.
    w_id_a = (r_wb_wr && (r_wb_rd == w_id_rs1)) ? r_wb_data : r_regs[w_id_rs1];
    w_id_b = (r_wb_wr && (r_wb_rd == w_id_rs2)) ? r_wb_data : r_regs[w_id_rs2];
    w_stall = r_idex_lw && r_idex_wr && w_id_valid &&
              ((r_idex_rd == w_id_rs1) || (w_id_use_rs2 && (r_idex_rd == w_id_rs2)));
  end

  always_comb begin
    w_fwd_a = r_idex_a;
    if (r_exmem_wr && !r_exmem_lw && (r_exmem_rd == r_idex_rs1)) w_fwd_a = r_exmem_res;
    else if (r_wb_wr && (r_wb_rd == r_idex_rs1)) w_fwd_a = r_wb_data;
    w_fwd_b = r_idex_b;
    if (r_exmem_wr && !r_exmem_lw && (r_exmem_rd == r_idex_rs2)) w_fwd_b = r_exmem_res;
    else if (r_wb_wr && (r_wb_rd == r_idex_rs2)) w_fwd_b = r_wb_data;
    w_alu_b = r_idex_use_imm ? r_idex_imm : w_fwd_b;
    case (r_idex_op)
      ALU_SUB: w_alu_res = w_fwd_a - w_fwd_b;
      ALU_SLL: w_alu_res = w_fwd_a << r_idex_imm[4:0];
      default: w_alu_res = w_fwd_a + w_alu_b;
    endcase
  end

  assign w_dmem_idx   = r_exmem_res[DW+1:2];
  assign w_dmem_rdata = r_dmem[w_dmem_idx];

  always_ff @(posedge clk) begin
    if (r_exmem_sw && !reset) r_dmem[w_dmem_idx] <= r_exmem_store;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (r_wb_wr) begin
      r_regs[r_wb_rd] <= r_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;           r_ifid_instr <= '0;
      r_idex_valid <= 1'b0; r_idex_wr <= 1'b0;  r_idex_lw <= 1'b0; r_idex_sw <= 1'b0;
      r_idex_use_imm <= 1'b0; r_idex_op <= ALU_ADD;
      r_idex_rd <= '0; r_idex_rs1 <= '0; r_idex_rs2 <= '0;
      r_idex_a <= '0;  r_idex_b <= '0;   r_idex_imm <= '0;
      r_exmem_valid <= 1'b0; r_exmem_wr <= 1'b0; r_exmem_lw <= 1'b0; r_exmem_sw <= 1'b0;
      r_exmem_rd <= '0; r_exmem_res <= '0; r_exmem_store <= '0;
      r_wb_valid <= 1'b0; r_wb_wr <= 1'b0; r_wb_rd <= '0; r_wb_data <= '0;
      r_retire_valid <= 1'b0; r_retire_count <= '0; r_stall_count <= '0;
    end else begin
      if (!w_stall) begin
        if (r_pc < PC_END) r_pc <= r_pc + (IW+1)'(1);
        r_ifid_instr <= w_fetch;
      end else begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      // A stall turns the ID/EX slot into a bubble by dropping its control bits.
      r_idex_valid   <= w_id_valid && !w_stall;
      r_idex_wr      <= w_id_wr && !w_stall;
      r_idex_lw      <= w_is_lw && !w_stall;
      r_idex_sw      <= w_is_sw && !w_stall;
      r_idex_use_imm <= w_id_use_imm;
      r_idex_op      <= w_id_op;
      r_idex_rd      <= w_id_rd;
      r_idex_rs1     <= w_id_rs1;
      r_idex_rs2     <= w_id_rs2;
      r_idex_a       <= w_id_a;
      r_idex_b       <= w_id_b;
      r_idex_imm     <= w_id_imm;

      r_exmem_valid  <= r_idex_valid;
      r_exmem_wr     <= r_idex_wr;
      r_exmem_lw     <= r_idex_lw;
      r_exmem_sw     <= r_idex_sw;
      r_exmem_rd     <= r_idex_rd;
      r_exmem_res    <= w_alu_res;
      r_exmem_store  <= w_fwd_b;

      r_wb_valid     <= r_exmem_valid;
      r_wb_wr        <= r_exmem_wr;
      r_wb_rd        <= r_exmem_rd;
      r_wb_data      <= r_exmem_lw ? w_dmem_rdata : r_exmem_res;

      r_retire_valid <= r_wb_valid;
      if (r_wb_valid) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign dbg_reg_data = (dbg_reg_addr == '0) ? '0 : r_regs[dbg_reg_addr];
  assign retire_valid = r_retire_valid;
  assign retire_count = r_retire_count;
  assign stall_count  = r_stall_count;
endmodule

// File: tb/tb_pipelined_core_fwd.sv
// Directed bench for pipelined_core_fwd: small programs with hand-computed
// register, counter and retire-timing results, plus an IMEM_DEPTH=8 instance.
module tb_pipelined_core_fwd;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, imem_we = 1'b0;
  logic [5:0]  imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_reg_addr = '0;
  logic [31:0] dbg_reg_data, retire_count, stall_count;
  logic        retire_valid;

  logic        reset8 = 1'b1, imem_we8 = 1'b0;
  logic [2:0]  imem_addr8 = '0;
  logic [31:0] imem_wdata8 = '0;
  logic [4:0]  dbg_reg_addr8 = '0;
  logic [31:0] dbg_reg_data8, retire_count8, stall_count8;
  logic        retire_valid8;

  int checks = 0, failures = 0;
  logic [31:0] prog [64];
  logic [31:0] v;

  pipelined_core_fwd u_dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .retire_valid(retire_valid), .retire_count(retire_count), .stall_count(stall_count));

  pipelined_core_fwd #(.IMEM_DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset8), .imem_we(imem_we8), .imem_addr(imem_addr8),
    .imem_wdata(imem_wdata8), .dbg_reg_addr(dbg_reg_addr8), .dbg_reg_data(dbg_reg_data8),
    .retire_valid(retire_valid8), .retire_count(retire_count8), .stall_count(stall_count8));

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] slli(input int rd, input int rs1, input int sh);
    return {7'b0, 5'(sh), 5'(rs1), 3'b001, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] rtype(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int imm, input int rs1);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int imm, input int rs1);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12[11:5], 5'(rs2), 5'(rs1), 3'b010, i12[4:0], 7'b0100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_reg(input int a, output logic [31:0] val);
    dbg_reg_addr = 5'(a);
    #1;
    val = dbg_reg_data;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
  endtask

  // Loads the whole IMEM under reset, then releases: the next edge is the first run edge.
  task automatic load_and_start();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      imem_we = 1'b1; imem_addr = 6'(i); imem_wdata = prog[i];
      tick();
    end
    imem_we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL reset_retire_valid: got %0b expected 0", retire_valid); end
    checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL reset_retire_count: got %0d expected 0", retire_count); end
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
    for (int r = 1; r < 32; r += 10) begin
      get_reg(r, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_reg x%0d: got %0d expected 0", r, v); end
    end
  endtask

  task automatic test_exmem_forward();
    clear_prog();
    prog[0] = addi(6, 0, 20);
    prog[1] = rtype(7'b0, 7, 6, 6);
    load_and_start();
    repeat (4) tick();
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL latency_cycle4: got %0b expected 0", retire_valid); end
    tick();
    checks++; if (retire_valid !== 1'b1) begin failures++; $display("FAIL latency_cycle5: got %0b expected 1", retire_valid); end
    checks++; if (retire_count !== 32'd1) begin failures++; $display("FAIL latency_count: got %0d expected 1", retire_count); end
    repeat (10) tick();
    get_reg(7, v);
    checks++; if (v !== 32'd40) begin failures++; $display("FAIL exmem_fwd x7: got %0d expected 40", v); end
    get_reg(6, v);
    checks++; if (v !== 32'd20) begin failures++; $display("FAIL exmem_fwd x6: got %0d expected 20", v); end
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL exmem_fwd stall_count: got %0d expected 0", stall_count); end
    checks++; if (retire_count !== 32'd2) begin failures++; $display("FAIL exmem_fwd retire_count: got %0d expected 2", retire_count); end
  endtask

  task automatic test_memwb_forward();
    clear_prog();
    prog[0] = addi(5, 0, 3);
    prog[2] = slli(10, 5, 3);
    load_and_start();
    repeat (15) tick();
    get_reg(10, v);
    checks++; if (v !== 32'd24) begin failures++; $display("FAIL memwb_fwd x10: got %0d expected 24", v); end
    checks++; if (retire_count !== 32'd2) begin failures++; $display("FAIL memwb_fwd retire_count: got %0d expected 2", retire_count); end
  endtask

  task automatic test_sub_negative();
    clear_prog();
    prog[0] = addi(1, 0, 5);
    prog[1] = addi(2, 0, 12);
    prog[2] = rtype(7'b0100000, 3, 1, 2);
    prog[3] = addi(4, 3, -1);
    load_and_start();
    repeat (15) tick();
    get_reg(3, v);
    checks++; if (v !== 32'hFFFF_FFF9) begin failures++; $display("FAIL sub x3: got %h expected fffffff9", v); end
    get_reg(4, v);
    checks++; if (v !== 32'hFFFF_FFF8) begin failures++; $display("FAIL addi_neg x4: got %h expected fffffff8", v); end
  endtask

  task automatic set_load_use_prog();
    clear_prog();
    prog[0] = addi(1, 0, 8);
    prog[1] = addi(2, 0, 77);
    prog[2] = sw(2, 4, 1);
    prog[3] = lw(12, 4, 1);
    prog[4] = rtype(7'b0, 13, 12, 12);
  endtask

  task automatic check_load_use(input string tag);
    get_reg(12, v);
    checks++; if (v !== 32'd77) begin failures++; $display("FAIL %s x12: got %0d expected 77", tag, v); end
    get_reg(13, v);
    checks++; if (v !== 32'd154) begin failures++; $display("FAIL %s x13: got %0d expected 154", tag, v); end
    checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL %s stall_count: got %0d expected 1", tag, stall_count); end
    checks++; if (retire_count !== 32'd5) begin failures++; $display("FAIL %s retire_count: got %0d expected 5", tag, retire_count); end
  endtask

  task automatic test_load_use();
    set_load_use_prog();
    load_and_start();
    repeat (16) tick();
    check_load_use("load_use");
  endtask

  task automatic test_x0();
    clear_prog();
    prog[0] = addi(0, 0, 5);
    prog[1] = rtype(7'b0, 3, 0, 0);
    load_and_start();
    repeat (12) tick();
    get_reg(0, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL x0_read: got %0d expected 0", v); end
    get_reg(3, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL x0_no_fwd x3: got %0d expected 0", v); end
    checks++; if (retire_count !== 32'd2) begin failures++; $display("FAIL x0 retire_count: got %0d expected 2", retire_count); end
  endtask

  task automatic test_mid_reset();
    set_load_use_prog();
    load_and_start();
    repeat (7) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    get_reg(1, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL midreset7 x1: got %0d expected 0", v); end
    checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL midreset7 retire_count: got %0d expected 0", retire_count); end
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL midreset7 stall_count: got %0d expected 0", stall_count); end
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL midreset3 retire_count: got %0d expected 0", retire_count); end
    repeat (4) tick();
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL rerun_cycle4: got %0b expected 0", retire_valid); end
    tick();
    checks++; if (retire_valid !== 1'b1) begin failures++; $display("FAIL rerun_cycle5: got %0b expected 1", retire_valid); end
    repeat (12) tick();
    check_load_use("rerun");
  endtask

  task automatic test_fetch_saturate();
    logic [31:0] p8 [8];
    for (int i = 0; i < 8; i++) p8[i] = 32'd0;
    p8[0] = addi(1, 0, 1);
    p8[1] = addi(2, 0, 2);
    p8[2] = addi(3, 0, 3);
    p8[3] = rtype(7'b0, 4, 1, 2);
    reset8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_we8 = 1'b1; imem_addr8 = 3'(i); imem_wdata8 = p8[i];
      tick();
    end
    imem_we8 = 1'b0;
    tick();
    reset8 = 1'b0;
    repeat (8) tick();
    checks++; if (retire_valid8 !== 1'b1) begin failures++; $display("FAIL sat_4th_retire valid: got %0b expected 1", retire_valid8); end
    checks++; if (retire_count8 !== 32'd4) begin failures++; $display("FAIL sat_4th_retire count: got %0d expected 4", retire_count8); end
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++; if (retire_valid8 !== 1'b0) begin failures++; $display("FAIL sat_idle cycle %0d: got %0b expected 0", c, retire_valid8); end
    end
    checks++; if (retire_count8 !== 32'd4) begin failures++; $display("FAIL sat_final count: got %0d expected 4", retire_count8); end
    dbg_reg_addr8 = 5'd4;
    #1;
    checks++; if (dbg_reg_data8 !== 32'd3) begin failures++; $display("FAIL sat x4: got %0d expected 3", dbg_reg_data8); end
  endtask

  initial begin
    test_reset();
    test_exmem_forward();
    test_memwb_forward();
    test_sub_negative();
    test_load_use();
    test_x0();
    test_mid_reset();
    test_fetch_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
